divider_arbiter: RTL
====================

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_LENGTH, default 16, operand/result width; TIMEOUT, default 64, maximum cycles waiting on div_done.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N has an operation pending.
REQ-005 reqN_dividend, reqN_divisor  input  WORD_LENGTH  requester N operands.
REQ-006 reqN_ready  output  1  request accepted this cycle when valid and ready are both high.
REQ-007 respN_valid  output  1  one-cycle pulse; the response for requester N is valid.
REQ-008 resp_result, resp_remainder  output  WORD_LENGTH  response data, shared by both requesters.
REQ-009 resp_error  output  1  qualifies respN_valid; high on divide-by-zero or timeout.
REQ-010 div_start  output  1  one-cycle launch pulse to the shared divider.
REQ-011 div_dividend, div_divisor  output  WORD_LENGTH  latched operands, held stable from ISSUE through WAIT.
REQ-012 div_done  input  1  divider completion; sampled only in WAIT.
REQ-013 div_result, div_remainder  input  WORD_LENGTH  divider outputs, valid when div_done is high.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESPOND.
REQ-016 IDLE arbitration: if only one reqN_valid is high, that requester SHALL be granted; if both are high, the requester indicated by the priority pointer SHALL be granted.
REQ-017 reqN_ready SHALL be combinational and high only in IDLE, only for the granted requester; at most one ready SHALL be high in any cycle.
REQ-018 On acceptance, the block SHALL latch the operands and the owner ID, and the priority pointer SHALL point to the other requester.
REQ-019 On acceptance with divisor != 0: transition to ISSUE.
REQ-020 On acceptance with divisor == 0: transition to RESPOND without launching the divider; result = all ones, remainder = dividend, resp_error = 1.
REQ-021 ISSUE SHALL last exactly one cycle with div_start = 1, then transition to WAIT.
REQ-022 In WAIT, a timeout counter SHALL start at 0 and increment each cycle.
REQ-023 In WAIT, when div_done = 1, the block SHALL capture div_result and div_remainder, set error = 0, and transition to RESPOND.
REQ-024 In WAIT, if the counter reaches TIMEOUT-1 without div_done, the block SHALL transition to RESPOND with result = 0, remainder = 0, and error = 1.
REQ-025 If div_done coincides with the timeout cycle, div_done SHALL take precedence.
REQ-026 RESPOND SHALL last one cycle: respN_valid = 1 for the owner only, resp_* driven from the captured registers, then transition to IDLE.
REQ-027 resp_result, resp_remainder and resp_error SHALL hold their last values between responses.
REQ-028 div_done outside WAIT SHALL be ignored.
REQ-029 Latency: acceptance in cycle k gives div_start in k+1; div_done in cycle m gives respN_valid in m+1.
REQ-030 Latency for a zero divisor: acceptance in cycle k gives respN_valid in k+1.
REQ-031 A new request SHALL be accepted no earlier than the cycle after RESPOND, giving back-to-back throughput of one operation per (divider latency + 3) cycles.

Reset
REQ-032 While reset = 1 at a clock edge, the state SHALL go to IDLE and the priority pointer to requester 0.
REQ-033 While reset = 1 at a clock edge, the counter and all captured registers SHALL clear to 0.
REQ-034 While reset = 1 at a clock edge, every output SHALL be 0, including reqN_ready.
REQ-035 Reset asserted mid-operation SHALL abort the operation with no respN_valid; the divider result arriving later SHALL be ignored.

Verification
REQ-036 Single request: req0 with 246/89, divider model done 16 cycles after start -> div_start pulses once, resp0_valid once with result 2, remainder 68, error 0.
REQ-037 Contention: req0 and req1 both valid from reset release, continuously -> grants alternate 0,1,0,1; each response goes only to its owner.
REQ-038 Divide-by-zero: req1 with 100/0 -> no div_start; resp1_valid the next cycle with result 0xFFFF, remainder 100, error 1.
REQ-039 Timeout: divider never asserts done -> resp_valid TIMEOUT+1 cycles after div_start with error 1 and result 0; a following request then completes normally.
REQ-040 Reset mid-WAIT: assert reset for 1 cycle, then apply div_done -> no respN_valid, busy 0, next grant goes to req0.
REQ-041 Spurious div_done in IDLE or ISSUE -> no response and no state change.

Source files
------------

// File: rtl/divider_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle divider.
// Divide-by-zero is answered locally; divider latency is bounded by a timeout.
module divider_arbiter #(
  parameter int WORD_LENGTH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [WORD_LENGTH-1:0] req0_dividend,
  input  logic [WORD_LENGTH-1:0] req0_divisor,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [WORD_LENGTH-1:0] req1_dividend,
  input  logic [WORD_LENGTH-1:0] req1_divisor,
  output logic                   req1_ready,
  output logic                   resp0_valid,
  output logic                   resp1_valid,
  output logic [WORD_LENGTH-1:0] resp_result,
  output logic [WORD_LENGTH-1:0] resp_remainder,
  output logic                   resp_error,
  output logic                   div_start,
  output logic [WORD_LENGTH-1:0] div_dividend,
  output logic [WORD_LENGTH-1:0] div_divisor,
  input  logic                   div_done,
  input  logic [WORD_LENGTH-1:0] div_result,
  input  logic [WORD_LENGTH-1:0] div_remainder,
  output logic                   busy
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t                 r_state, w_next;
  logic                   r_prio, r_owner;
  logic [CW-1:0]          r_cnt;
  logic [WORD_LENGTH-1:0] r_dividend, r_divisor;
  logic [WORD_LENGTH-1:0] r_cap_result, r_cap_rem;
  logic                   r_cap_err;
  logic [WORD_LENGTH-1:0] r_hold_result, r_hold_rem;
  logic                   r_hold_err;

  logic                   w_grant, w_accept, w_timeout, w_div_zero;
  logic [WORD_LENGTH-1:0] w_sel_dividend, w_sel_divisor;

  always_comb begin
    w_grant = r_prio;
    if (req0_valid && !req1_valid)      w_grant = 1'b0;
    else if (req1_valid && !req0_valid) w_grant = 1'b1;
  end

  assign w_accept       = (r_state == S_IDLE) && !reset && (req0_valid || req1_valid);
  assign w_sel_dividend = w_grant ? req1_dividend : req0_dividend;
  assign w_sel_divisor  = w_grant ? req1_divisor  : req0_divisor;
  assign w_div_zero     = (w_sel_divisor == '0);
  assign w_timeout      = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_div_zero ? S_RESPOND : S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (div_done || w_timeout) w_next = S_RESPOND;
      S_RESPOND: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Response data is muxed from the capture registers only during RESPOND so the
  // visible outputs keep their previous values while a new result is captured.
  always_comb begin
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    div_start      = 1'b0;
    busy           = 1'b0;
    resp0_valid    = 1'b0;
    resp1_valid    = 1'b0;
    resp_result    = r_hold_result;
    resp_remainder = r_hold_rem;
    resp_error     = r_hold_err;
    if (!reset) begin
      req0_ready  = w_accept && !w_grant;
      req1_ready  = w_accept && w_grant;
      div_start   = (r_state == S_ISSUE);
      busy        = (r_state != S_IDLE);
      resp0_valid = (r_state == S_RESPOND) && !r_owner;
      resp1_valid = (r_state == S_RESPOND) && r_owner;
      if (r_state == S_RESPOND) begin
        resp_result    = r_cap_result;
        resp_remainder = r_cap_rem;
        resp_error     = r_cap_err;
      end
    end
  end

  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio        <= 1'b0;
      r_owner       <= 1'b0;
      r_cnt         <= '0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_cap_result  <= '0;
      r_cap_rem     <= '0;
      r_cap_err     <= 1'b0;
      r_hold_result <= '0;
      r_hold_rem    <= '0;
      r_hold_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner    <= w_grant;
            r_prio     <= ~w_grant;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            if (w_div_zero) begin
              r_cap_result <= '1;
              r_cap_rem    <= w_sel_dividend;
              r_cap_err    <= 1'b1;
            end
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (div_done) begin
            r_cap_result <= div_result;
            r_cap_rem    <= div_remainder;
            r_cap_err    <= 1'b0;
          end else if (w_timeout) begin
            r_cap_result <= '0;
            r_cap_rem    <= '0;
            r_cap_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESPOND: begin
          r_hold_result <= r_cap_result;
          r_hold_rem    <= r_cap_rem;
          r_hold_err    <= r_cap_err;
        end
        default: ;
      endcase
    end
  end
endmodule
